// File: rtl/axis_maxpool_edge_strip.sv
`default_nettype none
// ============================================================================
// Module   : axis_maxpool_edge_strip
// Brief    : Strips zero edge pads from a maxpool AXI-Stream, masks by tkeep,
//            checks pad integrity and re-emits through a two-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module axis_maxpool_edge_strip #(
   parameter int UNITS        = 8,
   parameter int GROUPS       = 2,
   parameter int WORD_WIDTH   = 8,
   parameter int KERNEL_H_MAX = 3,
   parameter int BEATS_W      = 16,
   localparam int P           = KERNEL_H_MAX / 2,
   localparam int UNITS_EDGES = UNITS + 2 * P,
   localparam int NCG         = 2 * GROUPS,
   localparam int IN_LANES    = NCG * UNITS_EDGES,
   localparam int OUT_LANES   = NCG * UNITS
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic [IN_LANES*WORD_WIDTH-1:0]  s_axis_tdata,
   input  logic [IN_LANES-1:0]             s_axis_tkeep,
   input  logic                            s_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [OUT_LANES*WORD_WIDTH-1:0] m_axis_tdata,
   output logic [OUT_LANES-1:0]            m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            pad_error,
   output logic                            keep_error,
   output logic [BEATS_W-1:0]              beat_count,
   output logic                            frame_done
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic                            w_in;
   logic                            w_out;
   logic                            w_load_out;
   logic                            w_load_skid;
   logic                            w_skid_to_out;

   logic [OUT_LANES*WORD_WIDTH-1:0] w_data;
   logic [OUT_LANES-1:0]            w_keep;
   logic                            w_pad_hit;
   logic                            w_keep_hit;

   logic [OUT_LANES*WORD_WIDTH-1:0] r_out_data;
   logic [OUT_LANES-1:0]            r_out_keep;
   logic                            r_out_last;
   logic [OUT_LANES*WORD_WIDTH-1:0] r_skid_data;
   logic [OUT_LANES-1:0]            r_skid_keep;
   logic                            r_skid_last;
   logic                            r_pad_error;
   logic                            r_keep_error;
   logic [BEATS_W-1:0]              r_beat_count;
   logic                            r_frame_done;

   // Strip pads: unit u of column cg sits at padded lane u+P.
   for (genvar cg = 0; cg < NCG; cg++) begin : g_col
      for (genvar u = 0; u < UNITS; u++) begin : g_unit
         localparam int IN_L  = cg * UNITS_EDGES + u + P;
         localparam int OUT_L = cg * UNITS + u;
         assign w_keep[OUT_L] = s_axis_tkeep[IN_L];
         assign w_data[OUT_L*WORD_WIDTH +: WORD_WIDTH] =
            s_axis_tkeep[IN_L] ? s_axis_tdata[IN_L*WORD_WIDTH +: WORD_WIDTH]
                               : {WORD_WIDTH{1'b0}};
      end
   end

   if (P > 0) begin : g_chk
      logic [NCG*2*P-1:0] w_pad_lane;
      logic [NCG*2*P-1:0] w_kerr_lane;
      for (genvar cg = 0; cg < NCG; cg++) begin : g_col
         for (genvar k = 0; k < 2 * P; k++) begin : g_pad
            localparam int BASE = cg * UNITS_EDGES;
            localparam int E    = (k < P) ? k : UNITS + k;
            assign w_pad_lane[cg*2*P+k]  = |s_axis_tdata[(BASE+E)*WORD_WIDTH +: WORD_WIDTH];
            assign w_kerr_lane[cg*2*P+k] = s_axis_tkeep[BASE+E] != s_axis_tkeep[BASE+P];
         end
      end
      assign w_pad_hit  = |w_pad_lane;
      assign w_keep_hit = |w_kerr_lane;
   end else begin : g_nochk
      assign w_pad_hit  = 1'b0;
      assign w_keep_hit = 1'b0;
   end

   assign s_axis_tready = (r_state != S_FULL);
   assign m_axis_tvalid = (r_state != S_EMPTY);
   assign w_in          = s_axis_tvalid & s_axis_tready;
   assign w_out         = m_axis_tvalid & m_axis_tready;

   always_comb begin
      w_state_nxt   = r_state;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_in) begin
               w_state_nxt = S_ONE;
               w_load_out  = 1'b1;
            end
         end
         S_ONE: begin
            if (w_in && w_out) begin
               w_load_out = 1'b1;
            end else if (w_in) begin
               w_state_nxt = S_FULL;
               w_load_skid = 1'b1;
            end else if (w_out) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_out) begin
               w_state_nxt   = S_ONE;
               w_skid_to_out = 1'b1;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
         r_skid_data <= '0;
         r_skid_keep <= '0;
         r_skid_last <= 1'b0;
      end else begin
         if (w_load_out) begin
            r_out_data <= w_data;
            r_out_keep <= w_keep;
            r_out_last <= s_axis_tlast;
         end else if (w_skid_to_out) begin
            r_out_data <= r_skid_data;
            r_out_keep <= r_skid_keep;
            r_out_last <= r_skid_last;
         end
         if (w_load_skid) begin
            r_skid_data <= w_data;
            r_skid_keep <= w_keep;
            r_skid_last <= s_axis_tlast;
         end
      end
   end

   // Status: sticky flags, per-frame beat counter, frame completion pulse.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_pad_error  <= 1'b0;
         r_keep_error <= 1'b0;
         r_beat_count <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_out & r_out_last;
         if (w_in) begin
            if (w_pad_hit) begin
               r_pad_error <= 1'b1;
            end
            if (w_keep_hit) begin
               r_keep_error <= 1'b1;
            end
            if (s_axis_tlast) begin
               r_beat_count <= '0;
            end else if (r_beat_count != {BEATS_W{1'b1}}) begin
               r_beat_count <= r_beat_count + 1'b1;
            end
         end
      end
   end

   assign m_axis_tdata = r_out_data;
   assign m_axis_tkeep = r_out_keep;
   assign m_axis_tlast = r_out_last;
   assign pad_error    = r_pad_error;
   assign keep_error   = r_keep_error;
   assign beat_count   = r_beat_count;
   assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_axis_maxpool_edge_strip.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_maxpool_edge_strip
// Brief    : Self-checking bench for axis_maxpool_edge_strip (4 units, 1 group).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_maxpool_edge_strip;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_tvalid;
   logic        s_tready;
   logic [95:0] s_tdata;
   logic [11:0] s_tkeep;
   logic        s_tlast;
   logic        m_tvalid;
   logic        m_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tlast;
   logic        pad_error;
   logic        keep_error;
   logic [15:0] beat_count;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;
   int fd_count = 0;
   bit saw_not_ready = 0;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } exp_t;

   typedef struct {
      logic [95:0] d;
      logic [11:0] k;
      logic        l;
      logic [63:0] ed;
      logic [7:0]  ek;
   } vec_t;

   exp_t q[$];
   vec_t vecs[4];

   always #5 aclk = ~aclk;

   axis_maxpool_edge_strip #(
      .UNITS(4), .GROUPS(1), .WORD_WIDTH(8), .KERNEL_H_MAX(3), .BEATS_W(16)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .pad_error(pad_error), .keep_error(keep_error),
      .beat_count(beat_count), .frame_done(frame_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [95:0] d, input logic [11:0] k, input logic l);
      exp_t r;
      r.d = '0;
      r.k = '0;
      r.l = l;
      for (int c = 0; c < 2; c++) begin
         for (int u = 0; u < 4; u++) begin
            int e;
            int o;
            e = c * 6 + u + 1;
            o = c * 4 + u;
            r.k[o] = k[e];
            if (k[e]) r.d[o*8 +: 8] = d[e*8 +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [95:0] rand_clean();
      logic [95:0] d;
      d = '0;
      for (int c = 0; c < 2; c++)
         for (int u = 0; u < 4; u++)
            d[(c*6+u+1)*8 +: 8] = 8'($urandom_range(0, 255));
      return d;
   endfunction

   task automatic send(input logic [95:0] d, input logic [11:0] k, input logic l, input exp_t e);
      int  waited;
      bit  done;
      waited   = 0;
      done     = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      while (!done) begin
         @(negedge aclk);
         if (s_tready) begin
            q.push_back(e);
            done = 1;
         end
         @(posedge aclk);
         #1;
         if (!done) begin
            waited++;
            if (waited > 50) begin
               n_checks++;
               n_errors++;
               $display("FAIL send_timeout: got tready=0 for 50 cycles expected 1");
               done = 1;
            end
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      q.delete();
      areset = 1'b1;
      repeat (cycles) @(posedge aclk);
      #1;
      areset = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge aclk);
         #1;
         n++;
      end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   initial begin
      exp_t        e;
      bit          stall;
      logic [63:0] pd;
      logic [7:0]  pk;
      logic        pl;
      stall = 0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            stall = 0;
            continue;
         end
         if (stall) begin
            chk("stall_valid", 64'(m_tvalid), 64'd1);
            chk("stall_data", m_tdata, pd);
            chk("stall_keep", 64'(m_tkeep), 64'(pk));
            chk("stall_last", 64'(m_tlast), 64'(pl));
         end
         if (m_tvalid && m_tready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected: got beat %0h expected none", m_tdata);
            end else begin
               e = q.pop_front();
               chk("sb_data", m_tdata, e.d);
               chk("sb_keep", 64'(m_tkeep), 64'(e.k));
               chk("sb_last", 64'(m_tlast), 64'(e.l));
            end
         end
         if (!s_tready) saw_not_ready = 1;
         if (frame_done) fd_count++;
         stall = m_tvalid && !m_tready;
         pd = m_tdata;
         pk = m_tkeep;
         pl = m_tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0] d;
      logic [95:0] bp_d[6];
      exp_t        e;

      vecs[0] = '{d: 96'h00_14_13_12_11_00_00_04_03_02_01_00, k: 12'hFFF, l: 1'b0,
                  ed: 64'h14_13_12_11_04_03_02_01, ek: 8'hFF};
      vecs[1] = '{d: 96'h00_14_13_12_11_00_00_04_03_AA_01_00, k: 12'hFFB, l: 1'b0,
                  ed: 64'h14_13_12_11_04_03_00_01, ek: 8'hFD};
      vecs[2] = '{d: 96'h00_A4_5C_A2_A1_00_00_34_33_32_31_00, k: 12'hDFF, l: 1'b0,
                  ed: 64'hA4_00_A2_A1_34_33_32_31, ek: 8'hBF};
      vecs[3] = '{d: 96'h00_FF_FF_FF_FF_00_00_FF_FF_FF_FF_00, k: 12'hFFF, l: 1'b1,
                  ed: 64'hFF_FF_FF_FF_FF_FF_FF_FF, ek: 8'hFF};

      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;

      // T1 reset
      do_reset(2);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tready", 64'(s_tready), 64'd1);
      chk("rst_tdata", m_tdata, 64'd0);
      chk("rst_tkeep", 64'(m_tkeep), 64'd0);
      chk("rst_pad_error", 64'(pad_error), 64'd0);
      chk("rst_keep_error", 64'(keep_error), 64'd0);
      chk("rst_beat_count", 64'(beat_count), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);

      // T2/T4 table: pass-through, masking, one-cycle latency at full rate
      for (int i = 0; i < 4; i++) begin
         e.d = vecs[i].ed;
         e.k = vecs[i].ek;
         e.l = vecs[i].l;
         send(vecs[i].d, vecs[i].k, vecs[i].l, e);
         chk($sformatf("vec%0d_valid", i), 64'(m_tvalid), 64'd1);
         chk($sformatf("vec%0d_data", i), m_tdata, vecs[i].ed);
         chk($sformatf("vec%0d_keep", i), 64'(m_tkeep), 64'(vecs[i].ek));
      end
      drain();
      chk("tbl_pad_error", 64'(pad_error), 64'd0);
      chk("tbl_keep_error", 64'(keep_error), 64'd0);
      chk("tbl_beat_count", 64'(beat_count), 64'd0);

      // T3 backpressure
      for (int i = 0; i < 6; i++) bp_d[i] = rand_clean();
      saw_not_ready = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(bp_d[i], 12'hFFF, 1'b0, model(bp_d[i], 12'hFFF, 1'b0));
         end
         begin
            @(posedge aclk);
            #1;
            m_tready = 1'b0;
            repeat (4) @(posedge aclk);
            #1;
            m_tready = 1'b1;
         end
      join
      drain();
      chk("bp_saw_not_ready", 64'(saw_not_ready), 64'd1);
      chk("bp_beat_count", 64'(beat_count), 64'd6);

      // T5 errors
      chk("err_pad_before", 64'(pad_error), 64'd0);
      d = rand_clean();
      d[11*8 +: 8] = 8'h07;
      send(d, 12'hFFF, 1'b0, model(d, 12'hFFF, 1'b0));
      chk("err_pad_set", 64'(pad_error), 64'd1);
      chk("err_keep_clean", 64'(keep_error), 64'd0);
      d = rand_clean();
      send(d, 12'hFFF, 1'b0, model(d, 12'hFFF, 1'b0));
      chk("err_pad_sticky", 64'(pad_error), 64'd1);
      d = rand_clean();
      send(d, 12'hFFE, 1'b0, model(d, 12'hFFE, 1'b0));
      chk("err_keep_set", 64'(keep_error), 64'd1);
      drain();

      // T6 framing and mid-frame reset
      do_reset(1);
      chk("frm_pad_cleared", 64'(pad_error), 64'd0);
      chk("frm_keep_cleared", 64'(keep_error), 64'd0);
      fd_count = 0;
      for (int i = 0; i < 3; i++) begin
         d = rand_clean();
         send(d, 12'hFFF, i == 2, model(d, 12'hFFF, i == 2));
         chk($sformatf("frm_beat_count%0d", i), 64'(beat_count), (i == 2) ? 64'd0 : 64'(i + 1));
      end
      @(posedge aclk);
      #1;
      chk("frm_done_pulse", 64'(frame_done), 64'd1);
      @(posedge aclk);
      #1;
      chk("frm_done_clear", 64'(frame_done), 64'd0);
      chk("frm_done_count", 64'(fd_count), 64'd1);
      drain();

      m_tready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         d = rand_clean();
         send(d, 12'hFFF, 1'b0, model(d, 12'hFFF, 1'b0));
      end
      chk("mid_beat_count", 64'(beat_count), 64'd2);
      chk("mid_tready_full", 64'(s_tready), 64'd0);
      do_reset(1);
      chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_tready", 64'(s_tready), 64'd1);
      chk("mid_rst_beat_count", 64'(beat_count), 64'd0);
      chk("mid_rst_tdata", m_tdata, 64'd0);
      m_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("mid_flushed", 64'(m_tvalid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
